local_fifo_arbiter: RTL and testbench



---
 rtl/local_fifo_arbiter_pkg.sv | 15 +
 rtl/local_fifo_arbiter_rr_priority_encoder.sv | 34 +++
 rtl/local_fifo_arbiter.sv | 93 +++++++++
 tb/tb_local_fifo_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/local_fifo_arbiter_pkg.sv
// Shared readout types for the local FIFO arbiter: FSM state encoding and
// the read latency of the per-channel local FIFOs.
package readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } arb_state_t;

    // Cycles between the local read strobe and valid data on input_event.
    localparam int READ_LATENCY = 1;

endpackage

// File: rtl/local_fifo_arbiter_rr_priority_encoder.sv
// Combinational round-robin priority encoder: returns the first requesting
// channel strictly above last_grant, wrapping modulo NUMCHANNELS.
module rr_priority_encoder #(
    parameter int NUMCHANNELS = 64,
    parameter int CHW         = $clog2(NUMCHANNELS)
) (
    input  logic [NUMCHANNELS-1:0] req,
    input  logic [CHW-1:0]         last_grant,
    output logic [CHW-1:0]         grant,
    output logic                   any
);

    logic [NUMCHANNELS-1:0]   masked;
    logic [2*NUMCHANNELS-1:0] search;

    // Lower half holds only channels above last_grant; the upper copy of the
    // full request vector supplies the wrapped-around candidates.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUMCHANNELS; i++) begin
            masked[i] = req[i] & (i > int'(last_grant));
        end
        search = {req, masked};
        grant  = '0;
        for (int i = 2*NUMCHANNELS-1; i >= 0; i--) begin
            if (search[i]) begin
                grant = CHW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/local_fifo_arbiter.sv
// Round-robin readout of NUMCHANNELS local FIFOs into the shared FIFO.
// Optional macro PARITY_EN appends an odd-parity bit; otherwise the MSB is 0.
module local_fifo_arbiter
    import readout_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int NUMCHANNELS = 64,
    parameter int CHW         = $clog2(NUMCHANNELS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-2:0]       input_event [NUMCHANNELS],
    input  logic [NUMCHANNELS-1:0] local_fifo_empty,
    input  logic                   fifo_full,
    output logic [NUMCHANNELS-1:0] read_local_fifo_n,
    output logic                   write_fifo_n,
    output logic [WIDTH-1:0]       event_out,
    output logic [CHW-1:0]         grant_id,
    output logic                   busy
);

    arb_state_t             state_q;
    logic [CHW-1:0]         grant_q;
    logic [CHW-1:0]         last_grant_q;
    logic [NUMCHANNELS-1:0] rd_n_q;
    logic [WIDTH-1:0]       event_q;
    logic [CHW-1:0]         next_grant;
    logic                   any_req;
    logic [WIDTH-2:0]       data;
    logic                   parity;

    rr_priority_encoder #(
        .NUMCHANNELS (NUMCHANNELS),
        .CHW         (CHW)
    ) u_rr_enc (
        .req        (~local_fifo_empty),
        .last_grant (last_grant_q),
        .grant      (next_grant),
        .any        (any_req)
    );

    assign data = input_event[grant_q];

`ifdef PARITY_EN
    assign parity = ~^data;
`else
    assign parity = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CHW'(NUMCHANNELS-1);
            rd_n_q       <= '1;
            event_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req && !fifo_full) begin
                        grant_q <= next_grant;
                        rd_n_q  <= ~(NUMCHANNELS'(1) << next_grant);
                        state_q <= READ;
                    end
                end
                READ: begin
                    rd_n_q  <= '1;
                    state_q <= LATCH;
                end
                LATCH: begin
                    event_q      <= {parity, data};
                    last_grant_q <= grant_q;
                    state_q      <= WRITE;
                end
                WRITE: begin
                    if (!fifo_full) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The write strobe follows fifo_full within the WRITE cycle so a full flag
    // raised late in the transaction stalls here without losing the packet.
    assign write_fifo_n      = ~((state_q == WRITE) && !fifo_full);
    assign read_local_fifo_n = rd_n_q;
    assign event_out         = event_q;
    assign grant_id          = grant_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_local_fifo_arbiter.sv
// Self-checking bench for local_fifo_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_local_fifo_arbiter;

    localparam int W = 64;
    localparam int N = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-2:0]  ev [N];
    logic [N-1:0]  emp;
    logic          full;
    logic [N-1:0]  read_n;
    logic          write_n;
    logic [W-1:0]  event_out;
    logic [5:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int strobes = 0;
    int strobeLog [$];

    // Reference model: protocol phase, current/previous grant, pending packet.
    int          mPhase;
    int          mGrant;
    int          mLast;
    logic [63:0] mEvent;

    local_fifo_arbiter #(
        .WIDTH       (W),
        .NUMCHANNELS (N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .input_event       (ev),
        .local_fifo_empty  (emp),
        .fifo_full         (full),
        .read_local_fifo_n (read_n),
        .write_fifo_n      (write_n),
        .event_out         (event_out),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] packet(input logic [62:0] d);
`ifdef PARITY_EN
        return {~^d, d};
`else
        return {1'b0, d};
`endif
    endfunction

    function automatic int nextGrant(input int last, input logic [63:0] e);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (!e[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mGrant = 0;
        mLast  = N - 1;
        mEvent = '0;
    endtask

    task automatic checkAll();
        logic [63:0] expRd;
        expRd = (mPhase == 1) ? ~(64'd1 << mGrant) : {64{1'b1}};
        checkOutput("readStrobe", read_n, expRd);
        checkOutput("writeStrobe", {63'd0, write_n}, (mPhase == 3 && !full) ? 64'd0 : 64'd1);
        checkOutput("eventOut", event_out, mEvent);
        checkOutput("grantId", {58'd0, grant_id}, 64'(mGrant));
        checkOutput("busy", {63'd0, busy}, (mPhase != 0) ? 64'd1 : 64'd0);
    endtask

    task automatic modelStep();
        int g;
        case (mPhase)
            0: if (!full) begin
                g = nextGrant(mLast, emp);
                if (g >= 0) begin
                    mGrant = g;
                    mPhase = 1;
                end
            end
            1: mPhase = 2;
            2: begin
                mEvent = packet(ev[mGrant]);
                mLast  = mGrant;
                mPhase = 3;
            end
            default: if (!full) mPhase = 0;
        endcase
    endtask

    // Called just after a rising edge: drive inputs, check, advance one cycle.
    task automatic applyStimulus(input logic [63:0] e, input logic f);
        emp  = e;
        full = f;
        #1;
        checkAll();
        if (read_n != '1) begin
            strobes++;
            for (int i = 0; i < N; i++) if (!read_n[i]) strobeLog.push_back(i);
        end
        if (!write_n) writes++;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic waitPhase(input int ph, input logic [63:0] e, input logic f);
        int n;
        n = 0;
        while (mPhase != ph && n < 20) begin
            applyStimulus(e, f);
            n++;
        end
        if (mPhase != ph) checkOutput("waitPhaseTimeout", 64'(n), 64'd0);
    endtask

    task automatic clearCounts();
        writes  = 0;
        strobes = 0;
        strobeLog.delete();
    endtask

    initial begin
        logic [63:0] e;
        int          exp2 [6];
        exp2 = '{3, 7, 63, 3, 7, 63};

        reset = 1'b1;
        emp   = '1;
        full  = 1'b0;
        for (int i = 0; i < N; i++) ev[i] = {31'($urandom), $urandom};
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;

        // Single request on channel 0 straight out of reset.
        ev[0] = 63'h1234;
        clearCounts();
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('1, 1'b0);
        checkOutput("t1Event", {1'b0, event_out[62:0]}, 64'h1234);
        checkOutput("t1Writes", 64'(writes), 64'd1);
        checkOutput("t1Strobes", 64'(strobes), 64'd1);

        // Channels 3, 7 and 63 requesting continuously.
        e = '1;
        e[3] = 1'b0; e[7] = 1'b0; e[63] = 1'b0;
        clearCounts();
        for (int i = 0; i < 24; i++) applyStimulus(e, 1'b0);
        checkOutput("t2Writes", 64'(writes), 64'd6);
        checkOutput("t2Strobes", 64'(strobes), 64'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t2Order", (i < strobeLog.size()) ? 64'(strobeLog[i]) : 64'hFFFF, 64'(exp2[i]));
        end

        // Full asserted from LATCH for 10 cycles stalls WRITE.
        waitPhase(0, '1, 1'b0);
        e = '1;
        e[10] = 1'b0;
        waitPhase(2, e, 1'b0);
        clearCounts();
        for (int i = 0; i < 10; i++) applyStimulus(e, 1'b1);
        checkOutput("t3StallWrites", 64'(writes), 64'd0);
        checkOutput("t3StallReads", 64'(strobes), 64'd0);
        applyStimulus(e, 1'b0);
        checkOutput("t3Writes", 64'(writes), 64'd1);
        checkOutput("t3Reads", 64'(strobes), 64'd0);

        // Parity bit for data 0 and data 1.
        waitPhase(0, '1, 1'b0);
        e = '1;
        e[20] = 1'b0;
        ev[20] = 63'h0;
        for (int i = 0; i < 4; i++) applyStimulus(e, 1'b0);
`ifdef PARITY_EN
        checkOutput("parityZero", {63'd0, event_out[63]}, 64'd1);
`else
        checkOutput("parityZero", {63'd0, event_out[63]}, 64'd0);
`endif
        ev[20] = 63'h1;
        for (int i = 0; i < 4; i++) applyStimulus(e, 1'b0);
        checkOutput("parityOne", {63'd0, event_out[63]}, 64'd0);

        // Reset pulsed while a packet is held in WRITE.
        e = '1;
        e[5] = 1'b0;
        waitPhase(3, e, 1'b0);
        full = 1'b1;
        #1;
        checkAll();
        reset = 1'b1;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        reset = 1'b0;
        e[0] = 1'b0;
        clearCounts();
        for (int i = 0; i < 4; i++) applyStimulus(e, 1'b0);
        checkOutput("t5Writes", 64'(writes), 64'd1);
        checkOutput("t5FirstGrant", (strobeLog.size() > 0) ? 64'(strobeLog[0]) : 64'hFFFF, 64'd0);

        // Wrap-around from last grant 62 with requests on 62, 63 and 0.
        waitPhase(0, '1, 1'b0);
        e = '1;
        e[62] = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(e, 1'b0);
        e[63] = 1'b0; e[0] = 1'b0;
        clearCounts();
        for (int i = 0; i < 12; i++) applyStimulus(e, 1'b0);
        checkOutput("wrap0", (strobeLog.size() > 0) ? 64'(strobeLog[0]) : 64'hFFFF, 64'd63);
        checkOutput("wrap1", (strobeLog.size() > 1) ? 64'(strobeLog[1]) : 64'hFFFF, 64'd0);
        checkOutput("wrap2", (strobeLog.size() > 2) ? 64'(strobeLog[2]) : 64'hFFFF, 64'd62);

        // Randomized traffic with sparse requests and random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) ev[i] = {31'($urandom), $urandom};
            e = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) e = '1;
            applyStimulus(e, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
